// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame states, prefix codes
// and default timing parameters.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic [7:0] BREAK_CODE      = 8'hF0;
    localparam logic [7:0] EXT_CODE        = 8'hE0;
    localparam int         DEF_FILTER_LEN  = 8;
    localparam int         DEF_TIMEOUT_CYC = 100000;

    // Data bits plus parity bit must contain an odd number of ones.
    function automatic logic odd_parity_ok(input logic [7:0] byte_i, input logic par_i);
        return ^{byte_i, par_i};
    endfunction

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchronizer, FILTER_LEN-sample glitch filter and registered
// falling-edge strobe for the raw PS/2 clock line.
module ps2_sync_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = DEF_FILTER_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw_i,
    output logic fall_o
);

    localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN + 1) : 1;

    logic          meta_q;
    logic          sync_q;
    logic          filt_q;
    logic          fall_q;
    logic [CW-1:0] cnt_q;

    // NOTE: the line idles high, so every stage resets to 1; resetting to 0
    // would fake a falling edge right after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
            filt_q <= 1'b1;
            fall_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            meta_q <= raw_i;
            sync_q <= meta_q;
            fall_q <= 1'b0;
            if (sync_q == filt_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
                filt_q <= sync_q;
                cnt_q  <= '0;
                fall_q <= filt_q;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

    assign fall_o = fall_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 keyboard receiver: frames 11-bit serial words, checks odd parity and
// stop bit, folds F0/E0 prefixes into is_break/is_ext qualifiers.
module ps2_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = DEF_FILTER_LEN,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic       clk,
    input  logic       btnC,
    input  logic       PS2Clk,
    input  logic       data,
    output logic [7:0] scan_code,
    output logic       code_valid,
    output logic       is_break,
    output logic       is_ext,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic          rst_n;
    logic          strobe;
    logic          data_meta_q;
    logic          data_sync_q;
    ps2_state_e    state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] to_cnt_q;
    logic          pend_brk_q;
    logic          pend_ext_q;
    logic [7:0]    scan_q;
    logic          valid_q;
    logic          brk_q;
    logic          ext_q;
    logic          err_q;

    assign rst_n = btnC;

    ps2_sync_filter #(
        .FILTER_LEN (FILTER_LEN)
    ) u_clk_filter (
        .clk    (clk),
        .rst_n  (rst_n),
        .raw_i  (PS2Clk),
        .fall_o (strobe)
    );

    // Data is only sampled mid-bit on the filtered clock strobe, so a plain
    // synchronizer is enough here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            data_meta_q <= data;
            data_sync_q <= data_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            to_cnt_q   <= '0;
            pend_brk_q <= 1'b0;
            pend_ext_q <= 1'b0;
            scan_q     <= '0;
            valid_q    <= 1'b0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low each cycle so they stay one clock wide.
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            if (state_q == ST_IDLE) begin
                to_cnt_q <= '0;
                if (strobe && !data_sync_q) begin
                    state_q   <= ST_DATA;
                    bit_cnt_q <= '0;
                end
            end else if (strobe) begin
                to_cnt_q <= '0;
                case (state_q)
                    ST_DATA: begin
                        shift_q[bit_cnt_q] <= data_sync_q;
                        bit_cnt_q          <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= ST_PARITY;
                    end
                    ST_PARITY: begin
                        par_q   <= data_sync_q;
                        state_q <= ST_STOP;
                    end
                    ST_STOP: begin
                        state_q <= ST_IDLE;
                        if (data_sync_q && odd_parity_ok(shift_q, par_q)) begin
                            if (shift_q == BREAK_CODE) begin
                                pend_brk_q <= 1'b1;
                            end else if (shift_q == EXT_CODE) begin
                                pend_ext_q <= 1'b1;
                            end else begin
                                scan_q     <= shift_q;
                                brk_q      <= pend_brk_q;
                                ext_q      <= pend_ext_q;
                                valid_q    <= 1'b1;
                                pend_brk_q <= 1'b0;
                                pend_ext_q <= 1'b0;
                            end
                        end else begin
                            err_q      <= 1'b1;
                            pend_brk_q <= 1'b0;
                            pend_ext_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end else if (to_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                // Keyboard stalled mid-frame: drop it and any pending prefix.
                state_q    <= ST_IDLE;
                to_cnt_q   <= '0;
                err_q      <= 1'b1;
                pend_brk_q <= 1'b0;
                pend_ext_q <= 1'b0;
            end else begin
                to_cnt_q <= to_cnt_q + TW'(1);
            end
        end
    end

    assign scan_code  = scan_q;
    assign code_valid = valid_q;
    assign is_break   = brk_q;
    assign is_ext     = ext_q;
    assign frame_err  = err_q;

endmodule

// File: tb/tb_ps2_rx.sv
// Self-checking bench for ps2_rx: directed frames plus randomized traffic
// compared against a prefix-tracking reference model.
module tb_ps2_rx;

    localparam int FL   = 8;
    localparam int TO   = 1000;
    localparam int HALF = 100;

    logic       clk;
    logic       btnC;
    logic       PS2Clk;
    logic       data;
    logic [7:0] scan_code;
    logic       code_valid;
    logic       is_break;
    logic       is_ext;
    logic       frame_err;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int cv_cnt = 0;
    int fe_cnt = 0;
    int last_pulse_cyc = 0;
    int fall_cyc = 0;

    // Reference model state
    logic [7:0] m_scan;
    logic       m_brk, m_ext, m_pbrk, m_pext;

    ps2_rx #(
        .FILTER_LEN  (FL),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk        (clk),
        .btnC       (btnC),
        .PS2Clk     (PS2Clk),
        .data       (data),
        .scan_code  (scan_code),
        .code_valid (code_valid),
        .is_break   (is_break),
        .is_ext     (is_ext),
        .frame_err  (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (code_valid || frame_err) begin
            check("valid_err_exclusive", {31'd0, code_valid & frame_err}, 32'd0);
            last_pulse_cyc = cyc;
        end
        if (code_valid === 1'b1) cv_cnt++;
        if (frame_err === 1'b1) fe_cnt++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One PS/2 bit: data changes while the clock is high, optional 50 ns low glitch.
    task automatic send_bit(input logic b, input logic glitch);
        data = b;
        wait_cyc(30);
        if (glitch) begin
            PS2Clk = 1'b0;
            wait_cyc(5);
            PS2Clk = 1'b1;
            wait_cyc(HALF - 35);
        end else begin
            wait_cyc(HALF - 30);
        end
        PS2Clk   = 1'b0;
        fall_cyc = cyc;
        wait_cyc(HALF);
        PS2Clk = 1'b1;
    endtask

    task automatic send_bits(input logic [7:0] b, input logic bad_par, input logic stop,
                             input logic glitch, input int nbits);
        logic [10:0] fb;
        fb = {stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) send_bit(fb[i], glitch);
        data = 1'b1;
    endtask

    task automatic predict(input logic [7:0] b, input logic bad_par, input logic stop,
                           output int exp_cv, output int exp_fe);
        exp_cv = 0;
        exp_fe = 0;
        if (bad_par || !stop) begin
            exp_fe = 1;
            m_pbrk = 1'b0;
            m_pext = 1'b0;
        end else if (b == 8'hF0) begin
            m_pbrk = 1'b1;
        end else if (b == 8'hE0) begin
            m_pext = 1'b1;
        end else begin
            exp_cv = 1;
            m_scan = b;
            m_brk  = m_pbrk;
            m_ext  = m_pext;
            m_pbrk = 1'b0;
            m_pext = 1'b0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "_scan"}, {24'd0, scan_code}, {24'd0, m_scan});
        check({tag, "_brk"}, {31'd0, is_break}, {31'd0, m_brk});
        check({tag, "_ext"}, {31'd0, is_ext}, {31'd0, m_ext});
    endtask

    task automatic run_frame(input string tag, input logic [7:0] b, input logic bad_par,
                             input logic stop, input logic glitch);
        int cv0, fe0, exp_cv, exp_fe, lat;
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        predict(b, bad_par, stop, exp_cv, exp_fe);
        send_bits(b, bad_par, stop, glitch, 11);
        check({tag, "_valid_cnt"}, cv_cnt - cv0, exp_cv);
        check({tag, "_err_cnt"}, fe_cnt - fe0, exp_fe);
        check_outputs(tag);
        if (exp_cv + exp_fe > 0) begin
            lat = last_pulse_cyc - fall_cyc;
            check({tag, "_latency_ok"}, {31'd0, (lat >= FL + 2) && (lat <= FL + 4)}, 32'd1);
        end
    endtask

    initial begin
        int cv0, fe0, lat;
        logic [7:0] b;
        logic bp, st, gl;
        int r;

        btnC   = 1'b0;
        PS2Clk = 1'b1;
        data   = 1'b1;
        m_scan = 8'h00;
        m_brk  = 1'b0;
        m_ext  = 1'b0;
        m_pbrk = 1'b0;
        m_pext = 1'b0;
        wait_cyc(5);
        check("rst_valid", {31'd0, code_valid}, 32'd0);
        check("rst_err", {31'd0, frame_err}, 32'd0);
        check_outputs("rst");
        btnC = 1'b1;
        wait_cyc(20);

        // Plain make code, prefixed break, extended break, parity error
        run_frame("make45", 8'h45, 1'b0, 1'b1, 1'b0);
        run_frame("brk_pre", 8'hF0, 1'b0, 1'b1, 1'b0);
        run_frame("brk45", 8'h45, 1'b0, 1'b1, 1'b0);
        run_frame("ext_pre", 8'hE0, 1'b0, 1'b1, 1'b0);
        run_frame("ext_brk_pre", 8'hF0, 1'b0, 1'b1, 1'b0);
        run_frame("ext_brk75", 8'h75, 1'b0, 1'b1, 1'b0);
        run_frame("bad_par45", 8'h45, 1'b1, 1'b1, 1'b0);
        run_frame("bad_stop", 8'h33, 1'b0, 1'b0, 1'b0);

        // Timeout: pending ext prefix, then a stalled frame, then a good frame
        run_frame("to_pre", 8'hE0, 1'b0, 1'b1, 1'b0);
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send_bits(8'h1C, 1'b0, 1'b1, 1'b0, 4);
        wait_cyc(TO + 500);
        m_pbrk = 1'b0;
        m_pext = 1'b0;
        check("timeout_err_cnt", fe_cnt - fe0, 1);
        check("timeout_valid_cnt", cv_cnt - cv0, 0);
        lat = last_pulse_cyc - fall_cyc;
        check("timeout_latency_ok", {31'd0, (lat >= TO) && (lat <= TO + FL + 6)}, 32'd1);
        check_outputs("timeout");
        run_frame("after_to1C", 8'h1C, 1'b0, 1'b1, 1'b0);

        // Glitches plus reset mid-frame with a pending break prefix
        run_frame("gl_pre", 8'hF0, 1'b0, 1'b1, 1'b1);
        cv0 = cv_cnt;
        fe0 = fe_cnt;
        send_bits(8'h2A, 1'b0, 1'b1, 1'b1, 5);
        btnC = 1'b0;
        wait_cyc(10);
        m_scan = 8'h00;
        m_brk  = 1'b0;
        m_ext  = 1'b0;
        m_pbrk = 1'b0;
        m_pext = 1'b0;
        check_outputs("in_reset");
        btnC = 1'b1;
        wait_cyc(50);
        check("abort_valid_cnt", cv_cnt - cv0, 0);
        check("abort_err_cnt", fe_cnt - fe0, 0);
        run_frame("gl45", 8'h45, 1'b0, 1'b1, 1'b1);

        // Randomized back-to-back traffic
        for (int i = 0; i < 12; i++) begin
            r  = int'($urandom_range(0, 99));
            b  = (r < 25) ? 8'hF0 : (r < 40) ? 8'hE0 : 8'($urandom);
            bp = ($urandom_range(0, 7) == 0);
            st = ($urandom_range(0, 7) != 0);
            gl = 1'($urandom);
            run_frame("rand", b, bp, st, gl);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
